// File: rtl/lab3_resp_checker.sv
// lab3_resp_checker: checks (code, response) samples against a mod-2**CODE_W sequence and a loadable table.
// Define CHK_RESYNC_EN to resynchronise the expected code after an out-of-sequence sample.
module lab3_resp_checker #(
    parameter int CODE_W = 3,
    parameter int OUT_W  = 4,
    parameter int ERR_W  = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              tbl_we,
    input  logic [CODE_W-1:0] tbl_addr,
    input  logic [OUT_W-1:0]  tbl_data,
    input  logic              start,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    input  logic [OUT_W-1:0]  in_out,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              seq_err,
    output logic              first_err_valid,
    output logic [CODE_W-1:0] first_err_code
);
    localparam int DEPTH = 2 ** CODE_W;

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    state_t            state_q, state_d;
    logic [OUT_W-1:0]  tbl_q [DEPTH];
    logic [OUT_W-1:0]  tbl_d [DEPTH];
    logic [CODE_W-1:0] exp_code_q, exp_code_d;
    logic [CODE_W-1:0] cnt_q, cnt_d;
    logic [CODE_W-1:0] first_err_code_q, first_err_code_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              seq_err_q, seq_err_d;
    logic              first_err_valid_q, first_err_valid_d;
    logic              accept, code_bad, out_bad;

    assign accept   = in_valid && (state_q == CHECK);
    assign code_bad = in_code != exp_code_q;
    assign out_bad  = in_out != tbl_q[in_code];

    always_comb begin
        state_d           = state_q;
        tbl_d             = tbl_q;
        exp_code_d        = exp_code_q;
        cnt_d             = cnt_q;
        err_cnt_d         = err_cnt_q;
        seq_err_d         = seq_err_q;
        first_err_valid_d = first_err_valid_q;
        first_err_code_d  = first_err_code_q;
        if (state_q != CHECK) begin
            if (tbl_we) tbl_d[tbl_addr] = tbl_data;
            if (start) begin
                state_d           = CHECK;
                exp_code_d        = '0;
                cnt_d             = '0;
                err_cnt_d         = '0;
                seq_err_d         = 1'b0;
                first_err_valid_d = 1'b0;
                first_err_code_d  = '0;
            end
        end else if (accept) begin
            if (code_bad) seq_err_d = 1'b1;
            if (code_bad || out_bad) begin
                err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
                if (!first_err_valid_q) begin
                    first_err_valid_d = 1'b1;
                    first_err_code_d  = in_code;
                end
            end
`ifdef CHK_RESYNC_EN
            exp_code_d = code_bad ? in_code + CODE_W'(1) : exp_code_q + CODE_W'(1);
`else
            exp_code_d = exp_code_q + CODE_W'(1);
`endif
            cnt_d = cnt_q + CODE_W'(1);
            if (&cnt_q) state_d = DONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q           <= IDLE;
            tbl_q             <= '{default: '0};
            exp_code_q        <= '0;
            cnt_q             <= '0;
            err_cnt_q         <= '0;
            seq_err_q         <= 1'b0;
            first_err_valid_q <= 1'b0;
            first_err_code_q  <= '0;
        end else begin
            state_q           <= state_d;
            tbl_q             <= tbl_d;
            exp_code_q        <= exp_code_d;
            cnt_q             <= cnt_d;
            err_cnt_q         <= err_cnt_d;
            seq_err_q         <= seq_err_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_code_q  <= first_err_code_d;
        end
    end

    assign in_ready        = state_q == CHECK;
    assign busy            = state_q == CHECK;
    assign done            = state_q == DONE;
    assign pass            = done && (err_cnt_q == '0) && !seq_err_q;
    assign err_cnt         = err_cnt_q;
    assign seq_err         = seq_err_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_code  = first_err_code_q;
endmodule

// File: tb/tb_lab3_resp_checker.sv
// tb_lab3_resp_checker: directed runs against a behavioural model plus literal expectations.
module tb_lab3_resp_checker;
    logic       CLK = 1'b0;
    logic       RST_N, tbl_we, start, in_valid;
    logic [2:0] tbl_addr, in_code;
    logic [3:0] tbl_data, in_out;
    logic       in_ready, busy, done, pass, seq_err, first_err_valid;
    logic [7:0] err_cnt;
    logic [2:0] first_err_code;
    logic       s_in_ready, s_busy, s_done, s_pass, s_seq_err, s_fev;
    logic [1:0] s_err_cnt;
    logic [2:0] s_fec;

    lab3_resp_checker dut (
        .CLK(CLK), .RST_N(RST_N), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .start(start), .in_valid(in_valid), .in_code(in_code), .in_out(in_out),
        .in_ready(in_ready), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .seq_err(seq_err), .first_err_valid(first_err_valid), .first_err_code(first_err_code)
    );

    lab3_resp_checker #(.ERR_W(2)) dut_sat (
        .CLK(CLK), .RST_N(RST_N), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .start(start), .in_valid(in_valid), .in_code(in_code), .in_out(in_out),
        .in_ready(s_in_ready), .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err_cnt),
        .seq_err(s_seq_err), .first_err_valid(s_fev), .first_err_code(s_fec)
    );

    always #5 CLK = ~CLK;

`ifdef CHK_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    int n_tests = 0, n_fail = 0;
    bit chk_en = 1'b0;
    int gold [8] = '{3, 5, 6, 9, 10, 12, 15, 0};
    int codes [8], outs [8], gaps [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 checking, 2 done; error count kept unbounded and clipped on compare.
    int m_phase, m_err, m_exp, m_n, m_fc;
    bit m_seq, m_fv;
    int m_tbl [8];

    always @(posedge CLK) begin
        if (!RST_N) begin
            m_phase = 0; m_err = 0; m_exp = 0; m_n = 0; m_fc = 0; m_seq = 0; m_fv = 0;
            foreach (m_tbl[i]) m_tbl[i] = 0;
        end else if (m_phase != 1) begin
            if (tbl_we) m_tbl[tbl_addr] = int'(tbl_data);
            if (start) begin
                m_phase = 1; m_err = 0; m_exp = 0; m_n = 0; m_fc = 0; m_seq = 0; m_fv = 0;
            end
        end else if (in_valid) begin
            automatic bit bc = int'(in_code) != m_exp;
            automatic bit bo = int'(in_out) != m_tbl[in_code];
            if (bc) m_seq = 1;
            if (bc || bo) begin
                m_err++;
                if (!m_fv) begin m_fv = 1; m_fc = int'(in_code); end
            end
            m_exp = ((RESYNC && bc) ? int'(in_code) + 1 : m_exp + 1) % 8;
            m_n++;
            if (m_n == 8) m_phase = 2;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("in_ready", in_ready, m_phase == 1);
            check("busy", busy, m_phase == 1);
            check("done", done, m_phase == 2);
            check("pass", pass, m_phase == 2 && m_err == 0 && !m_seq);
            check("err_cnt", err_cnt, m_err > 255 ? 255 : m_err);
            check("err_cnt_sat", s_err_cnt, m_err > 3 ? 3 : m_err);
            check("seq_err", seq_err, m_seq);
            check("first_err_valid", first_err_valid, m_fv);
            check("first_err_code", first_err_code, m_fc);
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int c, input int o, input int g);
        in_valid = 1'b0;
        repeat (g) tick();
        in_valid = 1'b1;
        in_code = 3'(c);
        in_out = 4'(o);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_vec;
        for (int i = 0; i < 8; i++) send(codes[i], outs[i], gaps[i]);
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done;
        for (int i = 0; i < 10 && !done; i++) tick();
        check("done_wait", done, 1);
    endtask

    task automatic set_gold;
        for (int i = 0; i < 8; i++) begin codes[i] = i; outs[i] = gold[i]; gaps[i] = 0; end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_cnt, 0);
        check({tag, "_seq"}, seq_err, 0);
        check({tag, "_fev"}, first_err_valid, 0);
        check({tag, "_fec"}, first_err_code, 0);
    endtask

    initial begin
        RST_N = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
        start = 1'b0; in_valid = 1'b0; in_code = '0; in_out = '0;
        repeat (2) tick();
        check_all_zero("reset");
        RST_N = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tbl_we = 1'b1; tbl_addr = 3'(i); tbl_data = 4'(gold[i]);
            tick();
        end
        tbl_we = 1'b0;
        // clean back-to-back run: done exactly one cycle after the 8th accept
        do_start();
        check("start_busy", busy, 1);
        set_gold();
        run_vec();
        check("clean_done", done, 1);
        check("clean_pass", pass, 1);
        check("clean_err", err_cnt, 0);
        repeat (3) tick();
        check("clean_hold", pass, 1);
        // single bad response on code 5
        do_start();
        set_gold();
        outs[5] = 13;
        run_vec();
        check("bad5_err", err_cnt, 1);
        check("bad5_fec", first_err_code, 5);
        check("bad5_fev", first_err_valid, 1);
        check("bad5_pass", pass, 0);
        check("bad5_seq", seq_err, 0);
        // restart from DONE clears results
        do_start();
        check("restart_err", err_cnt, 0);
        check("restart_fev", first_err_valid, 0);
        check("restart_busy", busy, 1);
        // dropped code 2
        codes = '{0, 1, 3, 4, 5, 6, 7, 0};
        for (int i = 0; i < 8; i++) outs[i] = gold[codes[i]];
        run_vec();
        check("drop_err", err_cnt, RESYNC ? 1 : 6);
        check("drop_seq", seq_err, 1);
        check("drop_fec", first_err_code, 3);
        // gapped valid gives the same result as back-to-back
        do_start();
        set_gold();
        gaps = '{0, 2, 1, 3, 0, 2, 1, 1};
        run_vec();
        wait_done();
        check("gap_pass", pass, 1);
        check("gap_err", err_cnt, 0);
        // every response wrong: wide counter reaches 8, narrow one saturates at 3
        do_start();
        set_gold();
        for (int i = 0; i < 8; i++) outs[i] = gold[i] ^ 1;
        run_vec();
        check("all_bad_err", err_cnt, 8);
        check("all_bad_sat", s_err_cnt, 3);
        check("all_bad_fec", first_err_code, 0);
        // table write and start together: first compare sees the new entry
        tbl_we = 1'b1; tbl_addr = 3'd0; tbl_data = 4'd7; start = 1'b1;
        tick();
        tbl_we = 1'b0; start = 1'b0;
        set_gold();
        outs[0] = 7;
        run_vec();
        check("wr_start_pass", pass, 1);
        // reset mid-run after 4 accepts
        do_start();
        set_gold();
        for (int i = 0; i < 4; i++) send(i, gold[i], 0);
        RST_N = 1'b0;
        tick();
        check_all_zero("midrst");
        RST_N = 1'b1;
        // cleared table: all-zero responses must pass
        do_start();
        set_gold();
        foreach (outs[i]) outs[i] = 0;
        run_vec();
        check("zero_tbl_pass", pass, 1);
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
